// File: rtl/oh_demux_pkg.sv
// Shared helpers for the one-hot stream demultiplexer: select legality,
// one-hot to index conversion and default counter sizing.
package oh_demux_pkg;

  // Widest select the helpers accept; callers zero-extend narrower selects.
  localparam int unsigned OH_MAX_W = 64;

  // Default width of the illegal-select counter and its saturation value.
  localparam int unsigned ERR_CW_DEF = 8;
  localparam logic [ERR_CW_DEF-1:0] ERR_MAX_DEF = {ERR_CW_DEF{1'b1}};

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(logic [OH_MAX_W-1:0] v);
    logic nonzero;
    logic single;
    nonzero = (v != {OH_MAX_W{1'b0}});
    single  = ((v & (v - OH_MAX_W'(1))) == {OH_MAX_W{1'b0}});
    return nonzero & single;
  endfunction

  // Index of the highest set bit; meaningful only for a one-hot input.
  function automatic int unsigned oh_to_idx(logic [OH_MAX_W-1:0] v);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (v[i]) begin
        idx = unsigned'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/oh_slot.sv
// One-entry output buffer for a single demux channel. A load wins over a
// drain on the same edge so a channel can stream one beat per cycle.
module oh_slot #(
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [BW-1:0] d,
  output logic          v,
  output logic [BW-1:0] q
);

  logic          v_q;
  logic          v_d;
  logic [BW-1:0] q_q;
  logic [BW-1:0] q_d;

  // Next-state: load refills (even while draining), drain alone empties.
  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (load) begin
      v_d = 1'b1;
      q_d = d;
    end else if (drain) begin
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  // Buffer registers; payload only moves on a load so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      q_q <= {BW{1'b0}};
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign v = v_q;
  assign q = q_q;

endmodule

// File: rtl/oh_demux_stream.sv
// Registered one-hot demultiplexer: routes each accepted beat into the
// one-entry buffer of the channel named by in_sel. Non-one-hot beats are
// swallowed, flagged with err_pulse and counted in a saturating counter.
module oh_demux_stream
  import oh_demux_pkg::*;
#(
  parameter int OUT_NUM = 4,
  parameter int BW      = 4,
  parameter int ERR_CW  = ERR_CW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OUT_NUM-1:0] in_sel,
  input  logic [BW-1:0]      in_data,
  output logic [OUT_NUM-1:0] out_valid,
  input  logic [OUT_NUM-1:0] out_ready,
  output logic [BW-1:0]      out_data [OUT_NUM-1:0],
  output logic               err_pulse,
  output logic [ERR_CW-1:0]  err_cnt
);

  localparam int IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam logic [ERR_CW-1:0] ERR_MAX = {ERR_CW{1'b1}};

  logic                init_done_q;
  logic                err_pulse_q;
  logic                err_pulse_d;
  logic [ERR_CW-1:0]   err_cnt_q;
  logic [ERR_CW-1:0]   err_cnt_d;

  logic [OH_MAX_W-1:0] sel_ext_s;
  logic                legal_s;
  logic [IDX_W-1:0]    k_s;
  logic                ready_s;
  logic                accept_s;
  logic                illegal_acc_s;
  logic [OUT_NUM-1:0]  load_s;
  logic [OUT_NUM-1:0]  drain_s;
  logic [OUT_NUM-1:0]  buf_v_s;

  assign sel_ext_s = {{(OH_MAX_W-OUT_NUM){1'b0}}, in_sel};
  assign legal_s   = is_one_hot(sel_ext_s);
  assign k_s       = IDX_W'(oh_to_idx(sel_ext_s));

  // Ready: illegal beats always drop; legal ones need room in their slot.
  always_comb begin
    ready_s = 1'b0;
    if (!init_done_q) begin
      ready_s = 1'b0;
    end else if (!legal_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = ~buf_v_s[k_s] | out_ready[k_s];
    end
  end

  assign in_ready      = ready_s;
  assign accept_s      = in_valid & ready_s;
  assign illegal_acc_s = accept_s & ~legal_s;
  assign load_s        = (accept_s & legal_s) ? in_sel : {OUT_NUM{1'b0}};
  assign drain_s       = buf_v_s & out_ready;

  // Error pulse and saturating counter next-state.
  always_comb begin
    err_pulse_d = illegal_acc_s;
    err_cnt_d   = err_cnt_q;
    if (illegal_acc_s && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CW'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Control registers: init_done holds ready low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= {ERR_CW{1'b0}};
    end else begin
      init_done_q <= 1'b1;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

  for (genvar g = 0; g < OUT_NUM; g++) begin : g_slot
    oh_slot #(.BW(BW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s[g]),
      .drain (drain_s[g]),
      .d     (in_data),
      .v     (buf_v_s[g]),
      .q     (out_data[g])
    );
  end

  assign out_valid = buf_v_s;

endmodule

// File: doc/oh_demux_stream.md
# oh_demux_stream

- Registered one-hot demultiplexer with valid/ready handshake on both sides.
- Routes one input stream to one of `OUT_NUM` output channels, selected by a one-hot destination field carried with each beat.
- Each channel has a one-entry output buffer, so a stalled channel does not block beats addressed to other channels.
- Beats whose select is not one-hot are discarded and counted. The block is the fan-out counterpart of the team's one-hot mux.

## Interface

Parameters:
- `OUT_NUM`, default 4: number of output channels; must be ≥ 2.
- `BW`, default 4: data width in bits.
- `ERR_CW`, default 8: width of the illegal-select counter.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: block accepts the input beat.
- `in_sel`, in, `OUT_NUM`: one-hot destination select.
- `in_data`, in, `BW`: input payload.
- `out_valid`, out, `OUT_NUM`: per-channel valid.
- `out_ready`, in, `OUT_NUM`: per-channel ready.
- `out_data`, out, `OUT_NUM` x `BW` (unpacked array `[OUT_NUM-1:0]`): per-channel payload.
- `err_pulse`, out, 1: one-cycle pulse per discarded illegal beat.
- `err_cnt`, out, `ERR_CW`: saturating count of discarded beats.

## Operation

**Select legality**
- `legal` = `in_sel` has exactly one bit set.
- `k` = index of that set bit.

**Per-channel buffer**
- State: `buf_v[k]`, `buf_d[k]`.
- `out_valid[k] = buf_v[k]` and `out_data[k] = buf_d[k]`, both driven directly from flops.

**Input ready**
- `in_ready = init_done & (~legal | ~buf_v[k] | out_ready[k])`.
- Combinational on `in_sel` and `out_ready`.
- `init_done` is a flop: reset to 0, set to 1 on the first `clk` edge after `rst_n` deasserts, then stays 1.

**Transfers**
- Accept = `in_valid & in_ready`.
- Accept with `legal`: on the next edge `buf_v[k] <= 1` and `buf_d[k] <= in_data`.
- Accept with `~legal` (zero or multiple bits set): the beat is dropped. No buffer changes, `err_pulse <= 1` for one cycle, and `err_cnt` increments, saturating at `2^ERR_CW - 1`.
- Drain on channel k = `out_valid[k] & out_ready[k]`: clears `buf_v[k]` unless the same channel is loaded on the same edge.
- Load and drain on the same channel in the same cycle: the buffer stays valid and takes the new data (full throughput, one beat per cycle per channel).
- At most one channel loads per cycle. Any number of channels may drain in the same cycle.

**Data and stability**
- `buf_d` changes only on a load. The payload holds stable while `out_valid & ~out_ready`.
- Data bits of an empty buffer are don't-care but are held.
- Upstream must hold `in_valid`, `in_sel` and `in_data` until accepted. The block does not check this.

## Timing

- **Reset (async, immediate):**
  - `buf_v` = 0, `buf_d` = 0, `init_done` = 0.
  - `err_pulse` = 0, `err_cnt` = 0.
  - `out_valid` = 0, `in_ready` = 0.
- **After release:** `in_ready` is 0 for the first cycle and may assert from the second edge onward.
- **Latency:** an accept at edge N makes `out_valid[k]` 1 after edge N, with data visible in cycle N+1.
- `err_pulse` is asserted in the cycle after the illegal accept.
- **Reset mid-operation:** buffered beats are lost and no further outputs are produced. `err_cnt` returns to 0.
- **Counter saturation:** at `err_cnt` = max, further illegal beats still pulse `err_pulse`, but the count holds.
- **`in_sel` = 0 with `in_valid` = 1:** illegal. It is accepted and dropped whenever `init_done` = 1.

## Structure

- Package `oh_demux_pkg` holds:
  - function `is_one_hot(logic [N-1:0])`;
  - function `oh_to_idx`;
  - `localparam` for the counter max.
- Sub-module `oh_slot`, instantiated `OUT_NUM` times via `generate`:
  - one-entry valid/data buffer with `load`, `drain`, `d` inputs;
  - `v`, `q` outputs.
- Top level holds `init_done`, the legality/ready logic, the error pulse and the error counter.

## Test plan

- **Basic routing:** `OUT_NUM`=4, `BW`=4. After reset, send `in_sel`=4'b0100, `in_data`=4'hA with `out_ready`=4'hF. Required: `in_ready`=0 in the first cycle after release; `out_valid`=4'b0100 and `out_data[2]`=4'hA exactly one cycle after accept; no other channel valid.
- **Back-pressure isolation:** `out_ready[1]`=0. Send 4'h3 to channel 1, then 4'h5 to channel 1, then 4'h7 to channel 3. Required: the second channel-1 beat stalls (`in_ready`=0) while `out_data[1]` holds 4'h3. After the stall clears, channel 3 receives 4'h7.
- **Streaming:** continuous beats to channel 0 with `out_ready[0]`=1, data 1,2,3,…,16. Required: one beat per cycle, `in_ready` constantly 1, outputs in order with no gaps (simultaneous load/drain).
- **Illegal selects:** send `in_sel`=4'b0110 and then `in_sel`=4'b0000. Required: both accepted, `err_pulse` high one cycle each, `err_cnt`=2, all `out_valid`=0. With `ERR_CW`=2 and 5 illegal beats, `err_cnt` saturates at 3.
- **Reset mid-operation:** fill channels 0 and 2 with `out_ready`=0, then assert `rst_n`=0 asynchronously mid-cycle. Required: `out_valid`=0, `in_ready`=0 and `err_cnt`=0 immediately, with no stale beat emitted after release.
